// File: rtl/cpu_host_pkg.sv
// Shared types and defaults for the CPU polled-I/O host port.
// host_latency gives the request-edge to first-rsp_valid distance for a given timing.
package cpu_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    X_HI,
    X_LO,
    Y_HI,
    Y_LO,
    R_HI,
    R_LO,
    RESP
  } host_state_t;

  localparam int HOST_HOLD_DEF = 5;
  localparam int HOST_GAP_DEF  = 10;

  function automatic int host_latency(input int hold, input int gap);
    return 5 * hold + gap + 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that flags the final cycle of a phase.
// last is high while the count is 1; the count parks at 0 until the next load.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/cpu_host_port.sv
// Host initiator for the CPU polling loop: presents x then y with a four-phase readyIn
// handshake, captures the two CPU results and returns them over valid/ready.
module cpu_host_port
  import cpu_host_pkg::*;
#(
  parameter int N    = 8,
  parameter int HOLD = HOST_HOLD_DEF,
  parameter int GAP  = HOST_GAP_DEF
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_x,
  input  logic [N-1:0] req_y,
  output logic [N:0]   inport,
  input  logic [N-1:0] outport,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_x,
  output logic [N-1:0] rsp_y,
  output logic         busy
);

  localparam int MAXP = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(MAXP + 1);

  host_state_t   state, nxt;
  logic [N-1:0]  x_q, y_q;
  logic          load;
  logic [CW-1:0] load_val;
  logic          last;
  logic          req_fire;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign req_fire  = req_valid & req_ready;

  phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .Reset    (Reset),
    .load     (load),
    .load_val (load_val),
    .last     (last)
  );

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = CW'(HOLD);
    case (state)
      IDLE: if (req_fire) begin nxt = X_HI; load = 1'b1; end
      X_HI: if (last) begin nxt = X_LO; load = 1'b1; end
      X_LO: if (last) begin nxt = Y_HI; load = 1'b1; end
      Y_HI: if (last) begin nxt = Y_LO; load = 1'b1; end
      Y_LO: if (last) begin nxt = R_HI; load = 1'b1; end
      R_HI: if (last) begin nxt = R_LO; load = 1'b1; load_val = CW'(GAP); end
      R_LO: if (last) nxt = RESP;
      RESP: if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      rsp_x <= '0;
      rsp_y <= '0;
    end else begin
      state <= nxt;
      if (req_fire) begin
        x_q <= req_x;
        y_q <= req_y;
      end
      if (state == Y_LO && last) rsp_x <= outport;
      if (state == R_HI && last) rsp_y <= outport;
    end
  end

  // In IDLE y_q is the last data driven (or 0 after reset), so it doubles as the hold value.
  always_comb begin
    case (state)
      X_HI:       inport = {1'b1, x_q};
      X_LO:       inport = {1'b0, x_q};
      Y_HI, R_HI: inport = {1'b1, y_q};
      default:    inport = {1'b0, y_q};
    endcase
  end

endmodule

// File: tb/tb_cpu_host_port.sv
// Scoreboard bench for cpu_host_port: a small CPU model answers each phase sequence
// and expected result pairs are queued at request time, popped when rsp_valid appears.
module tb_cpu_host_port;
  import cpu_host_pkg::*;

  logic       clk = 1'b0;
  logic       Reset;
  logic       req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [7:0] req_x, req_y, outport, rsp_x, rsp_y;
  logic [8:0] inport;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  cpu_host_port #(.N(8), .HOLD(5), .GAP(10)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .inport    (inport),
    .outport   (outport),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_x     (rsp_x),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected inport for cycle c after the request edge (cycle 0 is the first X_HI cycle).
  function automatic logic [8:0] exp_in(input int c, input logic [7:0] x, input logic [7:0] y);
    if (c < 5)  return {1'b1, x};
    if (c < 10) return {1'b0, x};
    if (c < 15) return {1'b1, y};
    if (c < 20) return {1'b0, y};
    if (c < 25) return {1'b1, y};
    return {1'b0, y};
  endfunction

  task automatic txn(input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] xr, input logic [7:0] yr,
                     input int bp, input bit poke, input int abort_at);
    int cyc;
    bit done;
    logic [15:0] e;
    logic [7:0] hx, hy;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_x = x; req_y = y; outport = xr;
    sb.push_back({xr, yr});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_x = 8'h55; req_y = 8'hAA;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      if (cyc == abort_at) begin
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("abort_inport", inport, 9'h000);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        sb.delete();
        return;
      end
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        if (cyc < 35) chk($sformatf("inport_c%0d", cyc), inport, exp_in(cyc, x, y));
        outport = (cyc <= 19) ? xr : yr;
        if (poke && cyc == 11) begin req_valid = 1'b1; req_x = 8'd1; req_y = 8'd1; end
        if (poke && cyc == 12) req_valid = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    chk("latency", cyc + 1, host_latency(HOST_HOLD_DEF, HOST_GAP_DEF));
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("rsp_x", rsp_x, e[15:8]);
    chk("rsp_y", rsp_y, e[7:0]);
    hx = rsp_x; hy = rsp_y;
    rsp_ready = 1'b0;
    repeat (bp) begin
      @(negedge clk);
      chk("bp_hold", {rsp_x, rsp_y}, {hx, hy});
      chk("bp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_inport", inport, {1'b0, y});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_req_ready", req_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("idle_inport", inport, {1'b0, y});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx, ry;
    Reset = 1'b1; req_valid = 1'b1; req_x = 8'h11; req_y = 8'h22;
    rsp_ready = 1'b0; outport = 8'h00;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_inport", inport, 9'h000);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp", {rsp_x, rsp_y}, 16'h0000);
    end
    Reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Directed x=20, y=-30 with 20 cycles of back-pressure.
    txn(8'd20, 8'hE2, 8'h07, 8'h09, 20, 1'b0, -1);
    // Stray request during Y_HI must be ignored.
    txn(8'd20, 8'hE2, 8'h29, 8'hE4, 2, 1'b1, -1);
    // Reset in the 3rd X_HI cycle, then a clean transaction.
    txn(8'd3, 8'd4, 8'h33, 8'h44, 0, 1'b0, 2);
    txn(8'd3, 8'd4, 8'h18, 8'h06, 0, 1'b0, -1);

    // Random pairs in [-64, 63] against an affine CPU model (x+21, y+2).
    for (int i = 0; i < 10; i++) begin
      rx = 8'($urandom_range(0, 127) - 64);
      ry = 8'($urandom_range(0, 127) - 64);
      txn(rx, ry, rx + 8'd21, ry + 8'd2, int'($urandom_range(0, 3)), 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
